// File: rtl/hazard_unit_v2.sv
// Hazard and forwarding controller for the 5-stage pipeline: operand forwarding, load-use
// bubbles, mispredict flush, halt drain and saturating stall/flush performance counters.
module hazard_unit_v2 #(
  parameter int unsigned WORD_SIZE    = 16,
  parameter int unsigned RA_W         = 2,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 id_valid,
  input  logic                 id_uses_rs,
  input  logic                 id_uses_rt,
  input  logic [RA_W-1:0]      id_rs,
  input  logic [RA_W-1:0]      id_rt,
  input  logic                 id_is_halt,
  input  logic                 br_resolve,
  input  logic [WORD_SIZE-1:0] actual_target,
  input  logic [WORD_SIZE-1:0] predicted_pc,
  input  logic                 ex_valid,
  input  logic                 m_valid,
  input  logic                 wb_valid,
  input  logic                 ex_regwrite,
  input  logic                 m_regwrite,
  input  logic                 wb_regwrite,
  input  logic                 ex_is_load,
  input  logic [RA_W-1:0]      ex_dest,
  input  logic [RA_W-1:0]      m_dest,
  input  logic [RA_W-1:0]      wb_dest,
  input  logic                 if_ready,
  input  logic                 m_ready,
  output logic                 pc_write,
  output logic                 if_write,
  output logic                 id_write,
  output logic                 ex_write,
  output logic                 m_write,
  output logic                 if_bubble,
  output logic                 id_bubble,
  output logic                 redirect_valid,
  output logic [WORD_SIZE-1:0] redirect_pc,
  output logic                 btb_write,
  output logic [1:0]           fwd_a,
  output logic [1:0]           fwd_b,
  output logic                 halted,
  output logic [CNT_W-1:0]     stall_count,
  output logic [CNT_W-1:0]     flush_count
);

  localparam int unsigned FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {StRun, StFlush, StDrain, StHalted} state_e;

  state_e          state_q, state_d;
  logic [FC_W-1:0] fcnt_q, fcnt_d;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic            stall_inc, flush_inc;

  logic ex_a, m_a, wb_a, ex_b, m_b, wb_b;
  logic [1:0] fwd_a_raw, fwd_b_raw;
  logic load_use, mispredict;

  assign ex_a = ex_valid && ex_regwrite && (ex_dest == id_rs);
  assign m_a  = m_valid  && m_regwrite  && (m_dest  == id_rs);
  assign wb_a = wb_valid && wb_regwrite && (wb_dest == id_rs);
  assign ex_b = ex_valid && ex_regwrite && (ex_dest == id_rt);
  assign m_b  = m_valid  && m_regwrite  && (m_dest  == id_rt);
  assign wb_b = wb_valid && wb_regwrite && (wb_dest == id_rt);

  assign fwd_a_raw = ex_a ? 2'd1 : m_a ? 2'd2 : wb_a ? 2'd3 : 2'd0;
  assign fwd_b_raw = ex_b ? 2'd1 : m_b ? 2'd2 : wb_b ? 2'd3 : 2'd0;

  // A loaded value is not available until MEM, so an EX-stage load match must bubble.
  assign load_use   = id_valid && ex_is_load &&
                      ((id_uses_rs && ex_a) || (id_uses_rt && ex_b));
  assign mispredict = br_resolve && (actual_target != predicted_pc);

  assign redirect_pc = actual_target;
  assign stall_count = stall_q;
  assign flush_count = flush_q;

  always_comb begin
    pc_write       = 1'b1;
    if_write       = 1'b1;
    id_write       = 1'b1;
    ex_write       = 1'b1;
    m_write        = 1'b1;
    if_bubble      = 1'b0;
    id_bubble      = 1'b0;
    redirect_valid = 1'b0;
    btb_write      = 1'b0;
    halted         = 1'b0;
    fwd_a          = fwd_a_raw;
    fwd_b          = fwd_b_raw;
    flush_inc      = 1'b0;
    state_d        = state_q;
    fcnt_d         = fcnt_q;

    case (state_q)
      StRun: begin
        if (!m_ready) begin
          {pc_write, if_write, id_write, ex_write, m_write} = 5'b00000;
        end else if (load_use) begin
          pc_write  = 1'b0;
          if_write  = 1'b0;
          id_bubble = 1'b1;
        end else if (mispredict) begin
          redirect_valid = 1'b1;
          if_bubble      = 1'b1;
          btb_write      = 1'b1;
          flush_inc      = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = StFlush;
            fcnt_d  = FC_W'(FLUSH_CYCLES - 1);
          end
        end else begin
          btb_write = br_resolve;
          if (id_is_halt && id_valid) begin
            pc_write  = 1'b0;
            if_bubble = 1'b1;
            state_d   = StDrain;
          end else if (!if_ready) begin
            pc_write  = 1'b0;
            if_bubble = 1'b1;
          end
        end
      end
      StFlush: begin
        if (!m_ready) begin
          {pc_write, if_write, id_write, ex_write, m_write} = 5'b00000;
        end else begin
          if_bubble = 1'b1;
          pc_write  = if_ready;
          fcnt_d    = fcnt_q - FC_W'(1);
          if (fcnt_q == FC_W'(1)) state_d = StRun;
        end
      end
      StDrain: begin
        pc_write  = 1'b0;
        if_write  = 1'b0;
        id_bubble = 1'b1;
        ex_write  = m_ready;
        m_write   = m_ready;
        if (!ex_valid && !m_valid && !wb_valid) state_d = StHalted;
      end
      StHalted: begin
        {pc_write, if_write, id_write, ex_write, m_write} = 5'b00000;
        halted = 1'b1;
      end
      default: state_d = StRun;
    endcase

    stall_inc = ((state_q == StRun) || (state_q == StFlush)) && !pc_write;

    if (!reset_n) begin
      {pc_write, if_write, id_write, ex_write, m_write} = 5'b11111;
      if_bubble      = 1'b0;
      id_bubble      = 1'b0;
      redirect_valid = 1'b0;
      btb_write      = 1'b0;
      halted         = 1'b0;
      fwd_a          = 2'd0;
      fwd_b          = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StRun;
      fcnt_q  <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      if (stall_inc && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
      if (flush_inc && (flush_q != '1)) flush_q <= flush_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_unit_v2.sv
// Bench for hazard_unit_v2 (FLUSH_CYCLES=2, CNT_W=2): directed scenarios plus randomized
// traffic checked against a rule-level reference model.
module tb_hazard_unit_v2;

  localparam int FC   = 2;
  localparam int MAXC = 3;

  logic        clk;
  logic        reset_n;
  logic        id_valid, id_uses_rs, id_uses_rt, id_is_halt, br_resolve;
  logic [1:0]  id_rs, id_rt, ex_dest, m_dest, wb_dest;
  logic [15:0] actual_target, predicted_pc;
  logic        ex_valid, m_valid, wb_valid, ex_regwrite, m_regwrite, wb_regwrite, ex_is_load;
  logic        if_ready, m_ready;
  logic        pc_write, if_write, id_write, ex_write, m_write;
  logic        if_bubble, id_bubble, redirect_valid, btb_write, halted;
  logic [15:0] redirect_pc;
  logic [1:0]  fwd_a, fwd_b, stall_count, flush_count;
  logic [13:0] obs;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: 0 run, 1 flush, 2 drain, 3 halted.
  int m_mode  = 0;
  int m_left  = 0;
  int m_stall = 0;
  int m_flush = 0;

  hazard_unit_v2 #(
    .WORD_SIZE(16), .RA_W(2), .FLUSH_CYCLES(FC), .CNT_W(2)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .id_valid(id_valid), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_rs(id_rs), .id_rt(id_rt), .id_is_halt(id_is_halt),
    .br_resolve(br_resolve), .actual_target(actual_target), .predicted_pc(predicted_pc),
    .ex_valid(ex_valid), .m_valid(m_valid), .wb_valid(wb_valid),
    .ex_regwrite(ex_regwrite), .m_regwrite(m_regwrite), .wb_regwrite(wb_regwrite),
    .ex_is_load(ex_is_load), .ex_dest(ex_dest), .m_dest(m_dest), .wb_dest(wb_dest),
    .if_ready(if_ready), .m_ready(m_ready),
    .pc_write(pc_write), .if_write(if_write), .id_write(id_write),
    .ex_write(ex_write), .m_write(m_write),
    .if_bubble(if_bubble), .id_bubble(id_bubble),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .btb_write(btb_write),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  // {enables pc..m, if_bubble, id_bubble, redirect, btb, fwd_a, fwd_b, halted}
  assign obs = {pc_write, if_write, id_write, ex_write, m_write, if_bubble, id_bubble,
                redirect_valid, btb_write, fwd_a, fwd_b, halted};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [1:0] src_fwd(input logic [1:0] r);
    if (ex_valid && ex_regwrite && ex_dest == r) return 2'd1;
    if (m_valid && m_regwrite && m_dest == r)    return 2'd2;
    if (wb_valid && wb_regwrite && wb_dest == r) return 2'd3;
    return 2'd0;
  endfunction

  function automatic logic hazard();
    return id_valid && ex_is_load &&
           ((id_uses_rs && src_fwd(id_rs) == 2'd1) || (id_uses_rt && src_fwd(id_rt) == 2'd1));
  endfunction

  function automatic logic [13:0] model_out();
    logic [4:0] en;
    logic       ib, idb, rv, bw, h;
    en = 5'b11111; ib = 0; idb = 0; rv = 0; bw = 0; h = 0;
    if (!reset_n) return 14'b11111_0000_00_00_0;
    case (m_mode)
      0: begin
        if (!m_ready) en = 5'b00000;
        else if (hazard()) begin en = 5'b00111; idb = 1; end
        else if (br_resolve && actual_target != predicted_pc) begin ib = 1; rv = 1; bw = 1; end
        else begin
          bw = br_resolve;
          if ((id_is_halt && id_valid) || !if_ready) begin en = 5'b01111; ib = 1; end
        end
      end
      1: begin
        if (!m_ready) en = 5'b00000;
        else begin en = {if_ready, 4'b1111}; ib = 1; end
      end
      2: begin en = {3'b001, m_ready, m_ready}; idb = 1; end
      default: begin en = 5'b00000; h = 1; end
    endcase
    return {en, ib, idb, rv, bw, src_fwd(id_rs), src_fwd(id_rt), h};
  endfunction

  task automatic model_clock();
    logic [13:0] o;
    o = model_out();
    if (!reset_n) begin
      m_mode = 0; m_left = 0; m_stall = 0; m_flush = 0;
    end else begin
      if ((m_mode == 0 || m_mode == 1) && !o[13]) m_stall = (m_stall < MAXC) ? m_stall + 1 : MAXC;
      case (m_mode)
        0: begin
          if (o[6]) begin
            m_flush = (m_flush < MAXC) ? m_flush + 1 : MAXC;
            if (FC > 1) begin m_mode = 1; m_left = FC - 1; end
          end else if (m_ready && !hazard() && id_is_halt && id_valid) begin
            m_mode = 2;
          end
        end
        1: if (m_ready) begin
          m_left = m_left - 1;
          if (m_left == 0) m_mode = 0;
        end
        2: if (!ex_valid && !m_valid && !wb_valid) m_mode = 3;
        default: ;
      endcase
    end
  endtask

  task automatic tick();
    model_clock();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    id_valid = 0; id_uses_rs = 0; id_uses_rt = 0; id_rs = 0; id_rt = 0; id_is_halt = 0;
    br_resolve = 0; actual_target = 16'h0000; predicted_pc = 16'h0000;
    ex_valid = 0; m_valid = 0; wb_valid = 0; ex_regwrite = 0; m_regwrite = 0; wb_regwrite = 0;
    ex_is_load = 0; ex_dest = 0; m_dest = 0; wb_dest = 0; if_ready = 1; m_ready = 1;
  endtask

  task automatic do_reset();
    reset_n = 0;
    idle();
    tick();
    reset_n = 1;
    idle();
  endtask

  task automatic test_reset();
    reset_n = 0;
    idle();
    m_ready = 0; if_ready = 0; id_valid = 1; id_uses_rs = 1; id_rs = 1;
    ex_valid = 1; ex_regwrite = 1; ex_is_load = 1; ex_dest = 1;
    br_resolve = 1; actual_target = 16'h0040;
    #1;
    n_checks++;
    if (obs !== 14'b11111_0000_00_00_0)
      $display("FAIL reset_forced: got %b expected %b", obs, 14'b11111_0000_00_00_0);
    if (obs !== 14'b11111_0000_00_00_0) n_fail++;
    tick();
    tick();
    n_checks++;
    if (stall_count !== 2'd0 || flush_count !== 2'd0) begin
      $display("FAIL reset_counters: got %0d/%0d expected 0/0", stall_count, flush_count);
      n_fail++;
    end
    reset_n = 1;
    idle();
    #1;
    n_checks++;
    if (obs !== 14'b11111_0000_00_00_0) begin
      $display("FAIL reset_run: got %b expected %b", obs, 14'b11111_0000_00_00_0);
      n_fail++;
    end
  endtask

  task automatic test_forward();
    do_reset();
    m_valid = 1; m_regwrite = 1; m_dest = 1;
    wb_valid = 1; wb_regwrite = 1; wb_dest = 2;
    id_valid = 1; id_uses_rs = 1; id_uses_rt = 1; id_rs = 1; id_rt = 2;
    #1;
    n_checks++;
    if (obs !== 14'b11111_0000_10_11_0) begin
      $display("FAIL fwd_mem_wb: got %b expected %b", obs, 14'b11111_0000_10_11_0);
      n_fail++;
    end
    ex_valid = 1; ex_regwrite = 1; ex_dest = 1;
    #1;
    n_checks++;
    if (obs !== 14'b11111_0000_01_11_0) begin
      $display("FAIL fwd_ex_priority: got %b expected %b", obs, 14'b11111_0000_01_11_0);
      n_fail++;
    end
    ex_valid = 0; wb_regwrite = 0;
    #1;
    n_checks++;
    if (obs !== 14'b11111_0000_10_00_0) begin
      $display("FAIL fwd_invalid_ex: got %b expected %b", obs, 14'b11111_0000_10_00_0);
      n_fail++;
    end
  endtask

  task automatic test_load_use();
    do_reset();
    ex_valid = 1; ex_regwrite = 1; ex_is_load = 1; ex_dest = 2;
    id_valid = 1; id_uses_rs = 1; id_rs = 2; id_rt = 3;
    #1;
    n_checks++;
    if (obs !== 14'b00111_0100_01_00_0 || stall_count !== 2'd0) begin
      $display("FAIL load_use_stall: got %b/%0d expected %b/0", obs, stall_count,
               14'b00111_0100_01_00_0);
      n_fail++;
    end
    tick();
    ex_valid = 0; ex_regwrite = 0; ex_is_load = 0;
    m_valid = 1; m_regwrite = 1; m_dest = 2;
    #1;
    n_checks++;
    if (obs !== 14'b11111_0000_10_00_0 || stall_count !== 2'd1) begin
      $display("FAIL load_use_release: got %b/%0d expected %b/1", obs, stall_count,
               14'b11111_0000_10_00_0);
      n_fail++;
    end
    ex_valid = 1; ex_regwrite = 1; ex_is_load = 1; ex_dest = 2; id_uses_rs = 0;
    #1;
    n_checks++;
    if (obs !== 14'b11111_0000_01_00_0) begin
      $display("FAIL load_unused_src: got %b expected %b", obs, 14'b11111_0000_01_00_0);
      n_fail++;
    end
  endtask

  task automatic test_mispredict();
    do_reset();
    br_resolve = 1; actual_target = 16'h0040; predicted_pc = 16'h0011; if_ready = 0;
    id_valid = 1;
    #1;
    n_checks++;
    if (obs !== 14'b11111_1011_00_00_0 || redirect_pc !== 16'h0040 || flush_count !== 2'd0) begin
      $display("FAIL mispredict: got %b pc=%h cnt=%0d expected %b pc=0040 cnt=0", obs,
               redirect_pc, flush_count, 14'b11111_1011_00_00_0);
      n_fail++;
    end
    tick();
    idle();
    #1;
    n_checks++;
    if (obs !== 14'b11111_1000_00_00_0 || flush_count !== 2'd1) begin
      $display("FAIL flush_cycle: got %b/%0d expected %b/1", obs, flush_count,
               14'b11111_1000_00_00_0);
      n_fail++;
    end
    tick();
    #1;
    n_checks++;
    if (obs !== 14'b11111_0000_00_00_0) begin
      $display("FAIL flush_done: got %b expected %b", obs, 14'b11111_0000_00_00_0);
      n_fail++;
    end
    br_resolve = 1; actual_target = 16'h0012; predicted_pc = 16'h0012; if_ready = 0;
    #1;
    n_checks++;
    if (obs !== 14'b01111_1001_00_00_0 || flush_count !== 2'd1) begin
      $display("FAIL correct_predict: got %b/%0d expected %b/1", obs, flush_count,
               14'b01111_1001_00_00_0);
      n_fail++;
    end
  endtask

  task automatic test_mready_freeze();
    do_reset();
    br_resolve = 1; actual_target = 16'h0040; predicted_pc = 16'h0011; m_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (obs !== 14'b00000_0000_00_00_0) begin
        $display("FAIL mready_hold%0d: got %b expected %b", i, obs, 14'b00000_0000_00_00_0);
        n_fail++;
      end
      tick();
    end
    n_checks++;
    if (stall_count !== 2'd3 || flush_count !== 2'd0) begin
      $display("FAIL mready_counts: got %0d/%0d expected 3/0", stall_count, flush_count);
      n_fail++;
    end
    m_ready = 1;
    #1;
    n_checks++;
    if (obs !== 14'b11111_1011_00_00_0) begin
      $display("FAIL mready_redirect: got %b expected %b", obs, 14'b11111_1011_00_00_0);
      n_fail++;
    end
    tick();
    br_resolve = 0; m_ready = 0;
    #1;
    n_checks++;
    if (obs !== 14'b00000_0000_00_00_0 || flush_count !== 2'd1) begin
      $display("FAIL flush_frozen: got %b/%0d expected %b/1", obs, flush_count,
               14'b00000_0000_00_00_0);
      n_fail++;
    end
    tick();
    m_ready = 1;
    #1;
    n_checks++;
    if (obs !== 14'b11111_1000_00_00_0) begin
      $display("FAIL flush_resume: got %b expected %b", obs, 14'b11111_1000_00_00_0);
      n_fail++;
    end
    tick();
    #1;
    n_checks++;
    if (obs !== 14'b11111_0000_00_00_0 || flush_count !== 2'd1) begin
      $display("FAIL flush_once: got %b/%0d expected %b/1", obs, flush_count,
               14'b11111_0000_00_00_0);
      n_fail++;
    end
  endtask

  task automatic test_halt();
    do_reset();
    id_valid = 1; id_is_halt = 1; ex_valid = 1; m_valid = 1; wb_valid = 1;
    #1;
    n_checks++;
    if (obs !== 14'b01111_1000_00_00_0) begin
      $display("FAIL halt_enter: got %b expected %b", obs, 14'b01111_1000_00_00_0);
      n_fail++;
    end
    tick();
    id_valid = 0; id_is_halt = 0; ex_valid = 0; m_ready = 0;
    #1;
    n_checks++;
    if (obs !== 14'b00100_0100_00_00_0) begin
      $display("FAIL drain_mwait: got %b expected %b", obs, 14'b00100_0100_00_00_0);
      n_fail++;
    end
    tick();
    m_ready = 1; m_valid = 0;
    #1;
    n_checks++;
    if (obs !== 14'b00111_0100_00_00_0) begin
      $display("FAIL drain_step: got %b expected %b", obs, 14'b00111_0100_00_00_0);
      n_fail++;
    end
    tick();
    wb_valid = 0;
    #1;
    n_checks++;
    if (obs !== 14'b00111_0100_00_00_0) begin
      $display("FAIL drain_last: got %b expected %b", obs, 14'b00111_0100_00_00_0);
      n_fail++;
    end
    tick();
    br_resolve = 1; actual_target = 16'h0040; predicted_pc = 16'h0011; if_ready = 0;
    id_valid = 1; id_is_halt = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (obs !== 14'b00000_0000_00_00_1) begin
        $display("FAIL halted%0d: got %b expected %b", i, obs, 14'b00000_0000_00_00_1);
        n_fail++;
      end
      tick();
    end
    n_checks++;
    if (stall_count !== 2'd1 || flush_count !== 2'd0) begin
      $display("FAIL halt_counts: got %0d/%0d expected 1/0", stall_count, flush_count);
      n_fail++;
    end
  endtask

  task automatic test_saturation();
    do_reset();
    ex_valid = 1; ex_regwrite = 1; ex_is_load = 1; ex_dest = 1;
    id_valid = 1; id_uses_rt = 1; id_rt = 1;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_checks++;
      if (int'(stall_count) !== ((i < 3) ? i : 3)) begin
        $display("FAIL stall_sat%0d: got %0d expected %0d", i, stall_count, (i < 3) ? i : 3);
        n_fail++;
      end
      if (i < 5) tick();
    end
  endtask

  task automatic test_reset_mid_flush();
    do_reset();
    br_resolve = 1; actual_target = 16'h0040; predicted_pc = 16'h0011;
    tick();
    idle();
    m_ready = 0;
    tick();
    reset_n = 0;
    #1;
    n_checks++;
    if (obs !== 14'b11111_0000_00_00_0) begin
      $display("FAIL midflush_forced: got %b expected %b", obs, 14'b11111_0000_00_00_0);
      n_fail++;
    end
    tick();
    reset_n = 1;
    m_ready = 1;
    #1;
    n_checks++;
    if (obs !== 14'b11111_0000_00_00_0 || stall_count !== 2'd0 || flush_count !== 2'd0) begin
      $display("FAIL midflush_run: got %b %0d/%0d expected %b 0/0", obs, stall_count,
               flush_count, 14'b11111_0000_00_00_0);
      n_fail++;
    end
  endtask

  task automatic test_random();
    logic [13:0] exp_o;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      reset_n       = ($urandom_range(0, 60) != 0);
      id_valid      = ($urandom_range(0, 3) != 0);
      id_uses_rs    = ($urandom_range(0, 1) != 0);
      id_uses_rt    = ($urandom_range(0, 1) != 0);
      id_rs         = 2'($urandom_range(0, 3));
      id_rt         = 2'($urandom_range(0, 3));
      id_is_halt    = ($urandom_range(0, 30) == 0);
      br_resolve    = ($urandom_range(0, 3) == 0);
      actual_target = 16'h0010 + 16'($urandom_range(0, 2));
      predicted_pc  = 16'h0010 + 16'($urandom_range(0, 2));
      ex_valid      = ($urandom_range(0, 2) != 0);
      m_valid       = ($urandom_range(0, 2) != 0);
      wb_valid      = ($urandom_range(0, 2) != 0);
      ex_regwrite   = ($urandom_range(0, 1) != 0);
      m_regwrite    = ($urandom_range(0, 1) != 0);
      wb_regwrite   = ($urandom_range(0, 1) != 0);
      ex_is_load    = ($urandom_range(0, 2) == 0);
      ex_dest       = 2'($urandom_range(0, 3));
      m_dest        = 2'($urandom_range(0, 3));
      wb_dest       = 2'($urandom_range(0, 3));
      if_ready      = ($urandom_range(0, 3) != 0);
      m_ready       = ($urandom_range(0, 4) != 0);
      #1;
      exp_o = model_out();
      n_checks++;
      if (obs !== exp_o) begin
        $display("FAIL rand_outputs[%0d]: got %b expected %b", i, obs, exp_o);
        n_fail++;
      end
      n_checks++;
      if (int'(stall_count) !== m_stall || int'(flush_count) !== m_flush) begin
        $display("FAIL rand_counters[%0d]: got %0d/%0d expected %0d/%0d", i, stall_count,
                 flush_count, m_stall, m_flush);
        n_fail++;
      end
      n_checks++;
      if (redirect_pc !== actual_target) begin
        $display("FAIL rand_redirect_pc[%0d]: got %h expected %h", i, redirect_pc,
                 actual_target);
        n_fail++;
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_mispredict();
    test_mready_freeze();
    test_halt();
    test_saturation();
    test_reset_mid_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
